// File: rtl/pipe_stage.sv
// Reusable valid/ready pipeline stage register with an optional skid entry,
// flush/stall control and saturating bubble/squash counters for perf monitoring.
module pipe_stage #(
    parameter int WIDTH          = 32,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             stall,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] squash_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [CNT_W-1:0] r_bubble;
    logic [CNT_W-1:0] r_squash;

    logic       w_out_valid;
    logic       w_skid_full;
    logic [1:0] w_occ;
    logic       w_in_ready;
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_load_main;
    logic       w_load_skid;
    logic       w_pop_skid;

    // Add a small increment to a counter, clamping at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Output decode of the occupancy state.
    always_comb begin
        w_out_valid = 1'b0;
        w_skid_full = 1'b0;
        w_occ       = 2'd0;
        case (r_state)
            ST_EMPTY: begin
                w_out_valid = 1'b0;
            end
            ST_ONE: begin
                w_out_valid = 1'b1;
                w_occ       = 2'd1;
            end
            ST_TWO: begin
                w_out_valid = 1'b1;
                w_skid_full = 1'b1;
                w_occ       = 2'd2;
            end
            default: begin
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Ready: with a skid entry it depends only on state, so no path from out_ready/stall.
    always_comb begin
        w_in_ready = 1'b0;
        if (SKID != 0) begin
            w_in_ready = ~w_skid_full;
        end else begin
            w_in_ready = ~w_out_valid | (out_ready & ~stall);
        end
    end

    assign w_in_fire  = in_valid & w_in_ready & ~flush;
    assign w_out_fire = w_out_valid & out_ready & ~stall;

    // Next-state and datapath-load decode; flush overrides every transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_pop_skid  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end else if (w_in_fire && (SKID != 0)) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_TWO: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_ONE;
                    w_pop_skid  = 1'b1;
                end else begin
                    w_state_nxt = ST_TWO;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
            w_pop_skid  = 1'b0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload registers; the skid entry only ever drains into main, keeping FIFO order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= {WIDTH{1'b0}};
            r_skid <= {WIDTH{1'b0}};
        end else if (flush) begin
            if (CLEAR_ON_FLUSH != 0) begin
                r_main <= {WIDTH{1'b0}};
                r_skid <= {WIDTH{1'b0}};
            end else begin
                r_main <= r_main;
                r_skid <= r_skid;
            end
        end else begin
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_pop_skid) begin
                r_main <= r_skid;
            end else begin
                r_main <= r_main;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end else begin
                r_skid <= r_skid;
            end
        end
    end

    // Saturating bubble and squash counters; reset discards entries without counting them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble <= {CNT_W{1'b0}};
            r_squash <= {CNT_W{1'b0}};
        end else begin
            if (!w_out_valid) begin
                r_bubble <= sat_add(r_bubble, 2'd1);
            end else begin
                r_bubble <= r_bubble;
            end
            if (flush) begin
                r_squash <= sat_add(r_squash, w_occ);
            end else begin
                r_squash <= r_squash;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_data     = r_main;
    assign occupancy    = w_occ;
    assign bubble_count = r_bubble;
    assign squash_count = r_squash;

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register for the five-stage RISC-V core, replacing the hand-written per-stage registers with one reusable block. Carries a packed payload of WIDTH bits between adjacent stages using a valid/ready handshake. Supports an optional skid entry for full throughput with a registered `in_ready`, a flush that squashes held entries (branch redirect), and an explicit stall. Saturating bubble and squash counters feed the performance monitor.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `SKID`, 1: 1 = two-entry stage (main + skid), `in_ready` registered; 0 = single entry, `in_ready` combinational.
- `CLEAR_ON_FLUSH`, 1: 1 = payload registers zeroed on flush; 0 = payload retained, only valid cleared.
- `CNT_W`, 16: counter width (≥2).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  stage can accept payload.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  downstream payload valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  downstream payload (main entry).
- `flush`  in  1  squash all held entries and current input.
- `stall`  in  1  freeze output side; no output transfer this cycle.
- `occupancy`  out  2  entries held (0..2; max 1 when SKID=0).
- `bubble_count`  out  CNT_W  cycles with `out_valid`=0, saturating.
- `squash_count`  out  CNT_W  valid entries discarded by flush, saturating.

## Operation
- Definitions: `in_fire` = in_valid & in_ready & !flush; `out_fire` = out_valid & out_ready & !stall.
- Priority: rst > flush > normal transfer.
- States (SKID=1): EMPTY (occ 0), ONE (main valid), TWO (main + skid valid).
  - EMPTY: in_fire → ONE, main ← in_data.
  - ONE: in_fire & out_fire → ONE, main ← in_data; in_fire & !out_fire → TWO, skid ← in_data; !in_fire & out_fire → EMPTY; else hold.
  - TWO: `in_ready`=0; out_fire → ONE, main ← skid; else hold.
  - `in_ready` = registered !skid_valid (no combinational path from `out_ready`/`stall`).
- States (SKID=0): EMPTY, ONE. `in_ready` = !out_valid | (out_ready & !stall). ONE with in_fire & out_fire reloads main; out_fire alone → EMPTY.
- FIFO order always preserved; skid entry never bypasses main.
- Flush: next state EMPTY; `squash_count` += occupancy (0, 1 or 2) saturating at 2^CNT_W−1 (add clamps, never wraps). Input presented during flush is not captured and not counted. If CLEAR_ON_FLUSH=1, main and skid payloads ← 0.
- Flush and out_fire in same cycle: flush wins; the entry is counted as squashed, downstream must ignore the cycle (downstream also sees flush).
- Stall: output side frozen; input side still accepts while `in_ready`=1 (SKID=1 fills skid).
- `bubble_count` increments each non-reset cycle where `out_valid`=0, saturates at all-ones.
- `out_data` stable while out_valid & !out_fire.
- Upstream must hold `in_data` while in_valid & !in_ready; not checked.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, skid payload=0, `occupancy`=0, `in_ready`=1 (SKID=1; for SKID=0 follows formula → 1), `bubble_count`=0, `squash_count`=0.
- Reset mid-operation discards all entries without incrementing `squash_count`.
- Latency: in_fire in cycle N → `out_valid`=1 with that payload in cycle N+1.
- Throughput: one transfer per cycle with `out_ready`=1, `stall`=0, both SKID settings.
- SKID=1: after out_fire from TWO, `in_ready` returns to 1 the following cycle.
- Counters update on the same edge as the state change; visible the next cycle.

## Test plan
- Reset then idle 5 cycles, in_valid=0 → out_valid=0, bubble_count=5 (counted from first post-reset cycle), in_ready=1.
- SKID=1 streaming 0x11,0x22,0x33 with out_ready=1 → outputs appear cycles N+1..N+3 in order, occupancy stays 1, in_ready never drops.
- SKID=1, out_ready=0, push 0xA,0xB,0xC → 0xA main, 0xB skid, occupancy=2, in_ready=0, 0xC held upstream; raise out_ready → 0xA,0xB,0xC delivered in order.
- SKID=1 occupancy=2, assert flush one cycle → next cycle out_valid=0, occupancy=0, squash_count=2, out_data=0 (CLEAR_ON_FLUSH=1) or old 0xA (CLEAR_ON_FLUSH=0).
- stall=1 with out_ready=1, main holds 0x5 → out_data stays 0x5, no transfer; deassert stall → 0x5 transferred exactly once.
- CNT_W=2, 6 idle cycles → bubble_count saturates at 3; repeated flush of 2 entries → squash_count saturates at 3.
